// File: rtl/wb_stage_if.sv
// MEM-to-WB retirement bus plus the WB stage's register-file write port and status.
// master = MEM side / observer, slave = write-back stage.
interface wb_stage_if #(
  parameter int D_SIZE        = 32,
  parameter int ADDR_LINE_REG = 5
);
  logic                     valid_f_mem;
  logic [5:0]               opcode_f_mem;
  logic [D_SIZE-1:0]        alu_result_f_mem;
  logic [D_SIZE-1:0]        mem_data_f_mem;
  logic [ADDR_LINE_REG-1:0] rd_add_f_mem;
  logic                     mem_to_reg_f_mem;
  logic                     w_2_id;
  logic [ADDR_LINE_REG-1:0] addr_2_id;
  logic [D_SIZE-1:0]        write_data_2_id;
  logic                     halted;
  logic [31:0]              retired_cnt;
  logic [31:0]              reg_write_cnt;

  modport master (
    output valid_f_mem, opcode_f_mem, alu_result_f_mem, mem_data_f_mem,
           rd_add_f_mem, mem_to_reg_f_mem,
    input  w_2_id, addr_2_id, write_data_2_id, halted, retired_cnt, reg_write_cnt
  );

  modport slave (
    input  valid_f_mem, opcode_f_mem, alu_result_f_mem, mem_data_f_mem,
           rd_add_f_mem, mem_to_reg_f_mem,
    output w_2_id, addr_2_id, write_data_2_id, halted, retired_cnt, reg_write_cnt
  );
endinterface

// File: rtl/wb_stage.sv
// Write-back stage: registers the retiring instruction, drives the register-file
// write port, freezes on HALT and keeps saturating retire/write counters.
module wb_stage #(
  parameter int         D_SIZE        = 32,
  parameter int         ADDR_LINE_REG = 5,
  parameter logic [5:0] HALT_OPC      = 6'b010001,
  parameter logic [5:0] NOP_OPC       = 6'b111111,
  parameter logic [5:0] LDW_OPC       = 6'b001100
) (
  input  logic       clk,
  input  logic       reset,
  wb_stage_if.slave  bus
);
  typedef enum logic {RUN, HALTED} state_t;

  state_t                   r_state;
  logic                     r_valid;
  logic [5:0]               r_opc;
  logic [D_SIZE-1:0]        r_alu;
  logic [D_SIZE-1:0]        r_mem;
  logic [ADDR_LINE_REG-1:0] r_rd;
  logic                     r_m2r;
  logic [31:0]              r_ret_cnt;
  logic [31:0]              r_wr_cnt;

  logic w_run, w_halt, w_ret, w_we;

  assign w_run  = (r_state == RUN);
  assign w_halt = r_valid && (r_opc == HALT_OPC);
  assign w_ret  = r_valid && (r_opc != NOP_OPC);
  assign w_we   = r_valid && r_m2r && (r_rd != '0) && (r_opc != HALT_OPC) &&
                  (r_opc != NOP_OPC) && w_run;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= RUN;
      r_valid   <= 1'b0;
      r_opc     <= NOP_OPC;
      r_alu     <= '0;
      r_mem     <= '0;
      r_rd      <= '0;
      r_m2r     <= 1'b0;
      r_ret_cnt <= '0;
      r_wr_cnt  <= '0;
    end else if (w_run) begin
      if (w_ret && (r_ret_cnt != 32'hFFFF_FFFF)) r_ret_cnt <= r_ret_cnt + 32'd1;
      if (w_we  && (r_wr_cnt  != 32'hFFFF_FFFF)) r_wr_cnt  <= r_wr_cnt  + 32'd1;
      // A retiring HALT freezes the stage; whatever MEM presents now is dropped.
      if (w_halt || !bus.valid_f_mem) begin
        r_state <= w_halt ? HALTED : RUN;
        r_valid <= 1'b0;
        r_opc   <= NOP_OPC;
        r_alu   <= '0;
        r_mem   <= '0;
        r_rd    <= '0;
        r_m2r   <= 1'b0;
      end else begin
        r_valid <= 1'b1;
        r_opc   <= bus.opcode_f_mem;
        r_alu   <= bus.alu_result_f_mem;
        r_mem   <= bus.mem_data_f_mem;
        r_rd    <= bus.rd_add_f_mem;
        r_m2r   <= bus.mem_to_reg_f_mem;
      end
    end
  end

  assign bus.w_2_id          = w_we;
  assign bus.addr_2_id       = w_we ? r_rd : '0;
  assign bus.write_data_2_id = !w_we ? '0 : (r_opc == LDW_OPC) ? r_mem : r_alu;
  assign bus.halted          = (r_state == HALTED);
  assign bus.retired_cnt     = r_ret_cnt;
  assign bus.reg_write_cnt   = r_wr_cnt;
endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: directed retirements push expected writes,
// a negedge monitor pops and compares every register-file write.
module tb_wb_stage;
  logic clk;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  logic [36:0] exp_q[$];

  wb_stage_if #(.D_SIZE(32), .ADDR_LINE_REG(5)) bus ();

  wb_stage dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout req=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: act=%h req=%h", name, act, req);
    end
  endtask

  // Monitor: every write the DUT presents must match the oldest expected write.
  always @(negedge clk) begin
    if (!reset && bus.w_2_id === 1'b1) begin
      logic [36:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: act=%0d/%h req=none", bus.addr_2_id, bus.write_data_2_id);
      end else begin
        e = exp_q.pop_front();
        if ({bus.addr_2_id, bus.write_data_2_id} !== e) begin
          errors++;
          $display("FAIL write: act=%0d/%h req=%0d/%h", bus.addr_2_id, bus.write_data_2_id,
                   e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic push(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  // Present one input for one edge; returns 1 time unit after the capturing edge.
  task automatic send(input logic v, input logic [5:0] opc, input logic [4:0] rd,
                      input logic [31:0] alu, input logic [31:0] mem, input logic m2r);
    bus.valid_f_mem      = v;
    bus.opcode_f_mem     = opc;
    bus.rd_add_f_mem     = rd;
    bus.alu_result_f_mem = alu;
    bus.mem_data_f_mem   = mem;
    bus.mem_to_reg_f_mem = m2r;
    @(posedge clk);
    #1;
  endtask

  task automatic bubble();
    send(1'b0, 6'd0, 5'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic chk_cnt(input string name, input logic [31:0] ret, input logic [31:0] wr);
    chk({name, "_retired"}, bus.retired_cnt, ret);
    chk({name, "_regwrite"}, bus.reg_write_cnt, wr);
  endtask

  localparam logic [5:0] ADD  = 6'd0;
  localparam logic [5:0] ADDI = 6'd2;
  localparam logic [5:0] LDW  = 6'b001100;
  localparam logic [5:0] STW  = 6'd13;
  localparam logic [5:0] HALT = 6'b010001;
  localparam logic [5:0] NOP  = 6'b111111;
  localparam logic [5:0] UNK  = 6'b111000;

  initial begin
    reset = 1'b1;
    bus.valid_f_mem      = 1'b1;
    bus.opcode_f_mem     = ADD;
    bus.rd_add_f_mem     = 5'd9;
    bus.alu_result_f_mem = 32'h1234;
    bus.mem_data_f_mem   = 32'h5678;
    bus.mem_to_reg_f_mem = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w", {31'd0, bus.w_2_id}, 32'd0);
    chk("rst_addr", {27'd0, bus.addr_2_id}, 32'd0);
    chk("rst_data", bus.write_data_2_id, 32'd0);
    chk("rst_halted", {31'd0, bus.halted}, 32'd0);
    chk_cnt("rst", 32'd0, 32'd0);
    bus.valid_f_mem = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    push(5'd5, 32'h10);
    send(1'b1, ADD, 5'd5, 32'h10, 32'h0, 1'b1);
    chk("add_w", {31'd0, bus.w_2_id}, 32'd1);
    bubble();
    chk_cnt("add", 32'd1, 32'd1);

    push(5'd7, 32'hDEAD_BEEF);
    send(1'b1, LDW, 5'd7, 32'h100, 32'hDEAD_BEEF, 1'b1);
    send(1'b1, STW, 5'd9, 32'h44, 32'h0, 1'b0);
    chk("stw_w", {31'd0, bus.w_2_id}, 32'd0);
    chk_cnt("ldw", 32'd2, 32'd2);
    send(1'b1, ADDI, 5'd0, 32'h5, 32'h0, 1'b1);
    chk("r0_w", {31'd0, bus.w_2_id}, 32'd0);
    chk("r0_addr", {27'd0, bus.addr_2_id}, 32'd0);
    chk("r0_data", bus.write_data_2_id, 32'd0);
    chk_cnt("stw", 32'd3, 32'd2);
    bubble();
    chk_cnt("r0", 32'd4, 32'd2);

    push(5'd12, 32'hABC);
    send(1'b1, UNK, 5'd12, 32'hABC, 32'h999, 1'b1);
    bubble();
    chk_cnt("unk", 32'd5, 32'd3);

    send(1'b1, HALT, 5'd0, 32'd0, 32'd0, 1'b0);
    chk("halt_not_yet", {31'd0, bus.halted}, 32'd0);
    send(1'b1, ADD, 5'd3, 32'h77, 32'd0, 1'b1);
    chk("halted_rise", {31'd0, bus.halted}, 32'd1);
    chk_cnt("halt", 32'd6, 32'd3);
    send(1'b1, ADD, 5'd3, 32'h77, 32'd0, 1'b1);
    send(1'b1, ADD, 5'd3, 32'h77, 32'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      send(1'b1, ADD, 5'd3, 32'h77, 32'd0, 1'b1);
      chk("frozen_w", {31'd0, bus.w_2_id}, 32'd0);
      chk("frozen_halted", {31'd0, bus.halted}, 32'd1);
      chk_cnt("frozen", 32'd6, 32'd3);
    end

    // Mid-cycle reset while halted with an ADD on the inputs.
    #2;
    reset = 1'b1;
    #1;
    chk("mrst_halted", {31'd0, bus.halted}, 32'd0);
    chk("mrst_w", {31'd0, bus.w_2_id}, 32'd0);
    chk_cnt("mrst", 32'd0, 32'd0);
    @(posedge clk);
    #1;
    bus.valid_f_mem = 1'b0;
    @(negedge clk);
    reset = 1'b0;

    push(5'd1, 32'h11);
    send(1'b1, ADD, 5'd1, 32'h11, 32'd0, 1'b1);
    bubble();
    send(1'b1, NOP, 5'd4, 32'h55, 32'd0, 1'b1);
    push(5'd2, 32'h22);
    send(1'b1, ADD, 5'd2, 32'h22, 32'd0, 1'b1);
    bubble();
    bubble();
    push(5'd3, 32'h33);
    send(1'b1, ADD, 5'd3, 32'h33, 32'd0, 1'b1);
    send(1'b1, NOP, 5'd6, 32'h66, 32'd0, 1'b1);
    push(5'd31, 32'h44);
    send(1'b1, ADD, 5'd31, 32'h44, 32'd0, 1'b1);
    repeat (3) bubble();
    chk_cnt("mix", 32'd4, 32'd4);
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
